// File: rtl/ring_interlock_ctrl_pkg.sv
// Shared definitions for the ring-bus interlock controller: channel state
// encoding, timer sizing helper and forbidden-pattern slicing.
`ifndef RING_INTERLOCK_CTRL_PKG_SV
`define RING_INTERLOCK_CTRL_PKG_SV

`define RIC_PAT_SLICE(masks, p, n) masks[(p)*(n) +: (n)]

package ring_interlock_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_OPEN    = 3'd0,
        ST_CLOSING = 3'd1,
        ST_CLOSED  = 3'd2,
        ST_OPENING = 3'd3,
        ST_FAULT   = 3'd4
    } ch_state_t;

    function automatic int timer_width(input int t_close, input int t_open);
        int t_max;
        t_max = (t_close > t_open) ? t_close : t_open;
        return (t_max < 1) ? 1 : $clog2(t_max + 1);
    endfunction

endpackage

`endif

// File: rtl/ring_interlock_ctrl_channel.sv
// One contactor: open/close state machine with a shared supervision timer
// for closing, opening and unexpected-closure timeouts.
module contactor_channel
    import ring_interlock_ctrl_pkg::*;
#(
    parameter int T_CLOSE = 1000,
    parameter int T_OPEN  = 1000,
    parameter int CNT_W   = timer_width(T_CLOSE, T_OPEN)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       grant,
    input  logic       req,
    input  logic       fb,
    input  logic       fault_clr,
    output logic [2:0] state,
    output logic       cmd,
    output logic       eff
);

    localparam logic [CNT_W-1:0] CLOSE_LIM = CNT_W'(T_CLOSE - 1);
    localparam logic [CNT_W-1:0] OPEN_LIM  = CNT_W'(T_OPEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d, timer_inc;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        timer_inc = (timer_q == CNT_MAX) ? timer_q : timer_q + CNT_W'(1);
        case (state_q)
            ST_OPEN: begin
                // A closed aux contact while open means welded or released
                // after reset; it is tolerated for T_OPEN cycles only.
                if (grant) begin
                    state_d = ST_CLOSING;
                    timer_d = '0;
                end else if (fb) begin
                    if (timer_q >= OPEN_LIM) begin
                        state_d = ST_FAULT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end else begin
                    timer_d = '0;
                end
            end
            ST_CLOSING: begin
                if (!req) begin
                    state_d = ST_OPENING;
                    timer_d = '0;
                end else if (fb) begin
                    state_d = ST_CLOSED;
                    timer_d = '0;
                end else if (timer_q >= CLOSE_LIM) begin
                    state_d = ST_FAULT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            ST_CLOSED: begin
                if (!req) begin
                    state_d = ST_OPENING;
                    timer_d = '0;
                end else if (!fb) begin
                    state_d = ST_FAULT;
                end
            end
            ST_OPENING: begin
                if (!fb) begin
                    state_d = ST_OPEN;
                    timer_d = '0;
                end else if (timer_q >= OPEN_LIM) begin
                    state_d = ST_FAULT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            ST_FAULT: begin
                if (fault_clr && !fb) begin
                    state_d = ST_OPEN;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = ST_OPEN;
                timer_d = '0;
            end
        endcase
    end

    // The coil drive is taken from the next state so it is a clean flop output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_OPEN;
            timer_q <= '0;
            cmd     <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cmd     <= (state_d == ST_CLOSING) || (state_d == ST_CLOSED);
        end
    end

    assign state = state_q;
    assign eff   = ((state_q == ST_CLOSING) || (state_q == ST_CLOSED)) ? 1'b1 : fb;

endmodule

// File: rtl/ring_interlock_ctrl.sv
// Ring-bus interlock controller: permits contactor closures only when no
// forbidden pattern would be completed, granting at most one closure per cycle.
module ring_interlock_ctrl
    import ring_interlock_ctrl_pkg::*;
#(
    parameter int                     N_CH      = 8,
    parameter int                     N_PAT     = 7,
    parameter logic [N_PAT*N_CH-1:0]  PAT_MASKS = '0,
    parameter int                     T_CLOSE   = 1000,
    parameter int                     T_OPEN    = 1000,
    parameter int                     CNT_W     = timer_width(T_CLOSE, T_OPEN)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N_CH-1:0] i_req_close,
    input  logic [N_CH-1:0] i_fb,
    input  logic            i_fault_clr,
    output logic [N_CH-1:0] o_cmd,
    output logic [N_CH-1:0] o_closed,
    output logic [N_CH-1:0] o_blocked,
    output logic [N_CH-1:0] o_fault,
    output logic            o_busy
);

    localparam logic [N_CH-1:0] ONE_LSB  = N_CH'(1);
    localparam logic [N_CH-1:0] ALL_ONES = '1;

    logic [2:0]      ch_state [N_CH];
    logic [N_CH-1:0] eff, permit, grant, cand, is_open, is_busy, blocked_q;
    logic            found;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        contactor_channel #(
            .T_CLOSE (T_CLOSE),
            .T_OPEN  (T_OPEN),
            .CNT_W   (CNT_W)
        ) u_ch (
            .clk       (i_clk),
            .rst_n     (i_rst_n),
            .grant     (grant[g]),
            .req       (i_req_close[g]),
            .fb        (i_fb[g]),
            .fault_clr (i_fault_clr),
            .state     (ch_state[g]),
            .cmd       (o_cmd[g]),
            .eff       (eff[g])
        );

        assign is_open[g]  = (ch_state[g] == ST_OPEN);
        assign is_busy[g]  = (ch_state[g] == ST_CLOSING) || (ch_state[g] == ST_OPENING);
        assign o_closed[g] = (ch_state[g] == ST_CLOSED);
        assign o_fault[g]  = (ch_state[g] == ST_FAULT);
    end

    // Closing k is refused if k plus the already-effective contactors would
    // cover every member of some non-empty forbidden pattern.
    always_comb begin
        permit = ALL_ONES;
        for (int k = 0; k < N_CH; k++) begin
            for (int p = 0; p < N_PAT; p++) begin
                if ((`RIC_PAT_SLICE(PAT_MASKS, p, N_CH) != '0) &&
                    `RIC_PAT_SLICE(PAT_MASKS, p, N_CH)[k] &&
                    ((eff | ~`RIC_PAT_SLICE(PAT_MASKS, p, N_CH) | (ONE_LSB << k)) == ALL_ONES)) begin
                    permit[k] = 1'b0;
                end
            end
        end
    end

    assign cand = i_req_close & is_open & ~i_fb & permit;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (!found && cand[k]) begin
                grant[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            blocked_q <= '0;
        end else begin
            blocked_q <= i_req_close & is_open & ~permit;
        end
    end

    assign o_blocked = blocked_q;
    assign o_busy    = |is_busy;

endmodule

// File: tb/tb_ring_interlock_ctrl.sv
// Directed bench for ring_interlock_ctrl: 4 contactors, one ring-closure
// pattern, 8-cycle timeouts; aux feedback follows the coil 2 cycles later.
module tb_ring_interlock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       fault_clr;
    logic [3:0] force_open;
    logic [3:0] force_closed;
    logic [3:0] fb_d1, fb_d2;
    logic [3:0] fb;
    logic [3:0] cmd, closed, blocked, fault;
    logic       busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    ring_interlock_ctrl #(
        .N_CH      (4),
        .N_PAT     (1),
        .PAT_MASKS (4'b1111),
        .T_CLOSE   (8),
        .T_OPEN    (8)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_close (req),
        .i_fb        (fb),
        .i_fault_clr (fault_clr),
        .o_cmd       (cmd),
        .o_closed    (closed),
        .o_blocked   (blocked),
        .o_fault     (fault),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    // Contactor model: aux contact follows the coil two cycles later.
    always @(negedge clk) begin
        fb_d1 <= cmd;
        fb_d2 <= fb_d1;
    end

    assign fb = (fb_d2 & ~force_open) | force_closed;

    task automatic applyStimulus(input logic rst_v, input logic [3:0] req_v,
                                 input logic clr_v, input int cycles);
        rst_n     = rst_v;
        req       = req_v;
        fault_clr = clr_v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] observed,
                               input logic [3:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] e_cmd,
                            input logic [3:0] e_closed, input logic [3:0] e_blocked,
                            input logic [3:0] e_fault, input logic e_busy);
        checkOutput($sformatf("%s.cmd", tag), cmd, e_cmd);
        checkOutput($sformatf("%s.closed", tag), closed, e_closed);
        checkOutput($sformatf("%s.blocked", tag), blocked, e_blocked);
        checkOutput($sformatf("%s.fault", tag), fault, e_fault);
        checkOutput($sformatf("%s.busy", tag), {3'b000, busy}, {3'b000, e_busy});
    endtask

    initial begin
        force_open   = 4'b0000;
        force_closed = 4'b0000;
        applyStimulus(1'b0, 4'b0000, 1'b0, 3);
        checkAll("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

        $display("[TB] scenario 1: sequential closes, ring closure blocked");
        applyStimulus(1'b1, 4'b0001, 1'b0, 1);
        checkAll("s1.ch0_cmd", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0001, 1'b0, 2);
        checkAll("s1.ch0_closed", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b0011, 1'b0, 1);
        checkOutput("s1.ch1_cmd", cmd, 4'b0011);
        applyStimulus(1'b1, 4'b0011, 1'b0, 2);
        checkOutput("s1.ch1_closed", closed, 4'b0011);
        applyStimulus(1'b1, 4'b0111, 1'b0, 1);
        checkOutput("s1.ch2_cmd", cmd, 4'b0111);
        applyStimulus(1'b1, 4'b0111, 1'b0, 2);
        checkOutput("s1.ch2_closed", closed, 4'b0111);
        applyStimulus(1'b1, 4'b1111, 1'b0, 1);
        checkAll("s1.ch3_blocked", 4'b0111, 4'b0111, 4'b1000, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b1111, 1'b0, 6);
        checkAll("s1.ch3_held", 4'b0111, 4'b0111, 4'b1000, 4'b0000, 1'b0);

        $display("[TB] scenario 2: simultaneous requests, lowest index wins");
        applyStimulus(1'b0, 4'b0000, 1'b0, 3);
        applyStimulus(1'b1, 4'b0011, 1'b0, 5);
        checkOutput("s2.pre_closed", closed, 4'b0011);
        applyStimulus(1'b1, 4'b1111, 1'b0, 1);
        checkOutput("s2.grant_cmd", cmd, 4'b0111);
        checkOutput("s2.first_blocked", blocked, 4'b0000);
        applyStimulus(1'b1, 4'b1111, 1'b0, 1);
        checkOutput("s2.next_blocked", blocked, 4'b1000);
        checkOutput("s2.next_cmd", cmd, 4'b0111);

        $display("[TB] scenario 3: close timeout without feedback");
        applyStimulus(1'b0, 4'b0000, 1'b0, 3);
        force_open = 4'b0010;
        applyStimulus(1'b1, 4'b0010, 1'b0, 1);
        checkAll("s3.cmd_rise", 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0010, 1'b0, 7);
        checkAll("s3.before_timeout", 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0010, 1'b0, 1);
        checkAll("s3.timeout", 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0);

        $display("[TB] scenario 4: feedback loss while closed, clear and reclose");
        applyStimulus(1'b0, 4'b0000, 1'b0, 1);
        force_open = 4'b0000;
        applyStimulus(1'b0, 4'b0000, 1'b0, 2);
        applyStimulus(1'b1, 4'b0001, 1'b0, 3);
        checkOutput("s4.closed", closed, 4'b0001);
        force_open = 4'b0001;
        applyStimulus(1'b1, 4'b0001, 1'b0, 1);
        checkAll("s4.fb_lost", 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b1, 1);
        checkOutput("s4.cleared", fault, 4'b0000);
        force_open = 4'b0000;
        applyStimulus(1'b1, 4'b0001, 1'b0, 1);
        checkOutput("s4.reclose_cmd", cmd, 4'b0001);
        applyStimulus(1'b1, 4'b0001, 1'b0, 2);
        checkOutput("s4.reclosed", closed, 4'b0001);

        $display("[TB] scenario 5: reset mid-closing, stuck feedback after release");
        applyStimulus(1'b0, 4'b0000, 1'b0, 3);
        applyStimulus(1'b1, 4'b0100, 1'b0, 1);
        checkOutput("s5.closing_cmd", cmd, 4'b0100);
        force_closed = 4'b0100;
        applyStimulus(1'b0, 4'b0100, 1'b0, 1);
        checkAll("s5.reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b0, 7);
        checkAll("s5.fb_7cyc", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1);
        checkOutput("s5.fb_8cyc", fault, 4'b0100);
        applyStimulus(1'b1, 4'b0000, 1'b1, 1);
        checkOutput("s5.clear_ignored", fault, 4'b0100);
        force_closed = 4'b0000;
        applyStimulus(1'b1, 4'b0000, 1'b1, 1);
        checkOutput("s5.clear_taken", fault, 4'b0000);

        $display("[TB] scenario 6: request drop during closing");
        applyStimulus(1'b0, 4'b0000, 1'b0, 3);
        applyStimulus(1'b1, 4'b0001, 1'b0, 1);
        checkAll("s6.closing", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1);
        checkAll("s6.opening", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1);
        checkOutput("s6.opening_fb_high", {3'b000, busy}, 4'b0001);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1);
        checkAll("s6.open", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/ring_interlock_ctrl.md
Name: ring_interlock_ctrl

Overview:
- Parametrised, sequential ring-bus interlock controller for N_CH contactors.
- Arbitrates close requests against a configurable table of forbidden closure patterns (loop/paralleling combinations).
- Drives contactor coil commands and supervises feedback with open/close timeouts.
- Sits between the operator/PLC request layer and the contactor driver outputs; replaces per-contactor combinational interlock equations.

Parameters:
- N_CH, 8: number of contactors in the ring.
- N_PAT, 7: number of forbidden patterns.
- PAT_MASKS, all-zero, N_PAT*N_CH bits: pattern p occupies bits [p*N_CH +: N_CH]; bit k set means contactor k participates. An all-zero pattern is ignored.
- T_CLOSE, 1000: cycles allowed for feedback to confirm closed.
- T_OPEN, 1000: cycles allowed for feedback to confirm open.
- CNT_W, clog2(max(T_CLOSE,T_OPEN)+1): per-channel timer width.

Ports:
- i_clk, input, 1: system clock.
- i_rst_n, input, 1: **one clock; reset is synchronous and active-low.**
- i_req_close, input, N_CH: level request; 1 = close contactor k, 0 = open it.
- i_fb, input, N_CH: auxiliary-contact feedback, already synchronised; 1 = closed.
- i_fault_clr, input, 1: pulse; clears faulted channels whose feedback is open.
- o_cmd, output, N_CH: registered coil command.
- o_closed, output, N_CH: registered; channel in CLOSED state.
- o_blocked, output, N_CH: registered; request present but refused by interlock.
- o_fault, output, N_CH: registered; channel in FAULT.
- o_busy, output, 1: registered; any channel in CLOSING or OPENING.

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - All channels go to OPEN.
  - All timers are cleared.
  - All outputs are 0 after that edge, including o_cmd mid-operation.
- Channel states are OPEN, CLOSING, CLOSED, OPENING and FAULT.
- Effective-closed vector eff[k]:
  - eff[k] = 1 in CLOSING or CLOSED.
  - eff[k] = i_fb[k] in OPEN, OPENING or FAULT. Pending, faulted and unconfirmed-open contactors are treated conservatively as closed.
- Permit for contactor k:
  - permit[k] = 0 if some pattern p has bit k set and every other set bit of p has eff=1. Patterns not containing k are ignored.
  - A single-bit pattern {k} permanently forbids k.
- Grant:
  - At most one OPEN->CLOSING transition per cycle.
  - The winner is the lowest index k with i_req_close[k]=1, state OPEN, i_fb[k]=0 and permit[k]=1.
  - Permit is computed from the current-cycle eff, so two requests can never jointly complete a pattern.
- o_blocked[k] is registered next cycle as: i_req_close[k] & OPEN & ~permit[k]. A request that is permitted but loses arbitration is not blocked.
- Latency: request seen at edge t and granted gives state CLOSING and o_cmd=1 after edge t+1.
- OPEN state:
  - o_cmd=0.
  - If fb=1, the timer counts; reaching T_OPEN -> FAULT (welded or unexpected closure, also covers post-reset release).
  - If fb=0, the timer is cleared.
- CLOSING state:
  - o_cmd=1; the timer counts from 0.
  - fb=1 -> CLOSED.
  - Timer reaching T_CLOSE-1 without fb -> FAULT.
  - Request drop -> OPENING with the timer restarted. Request drop has priority over fb in the same cycle.
- CLOSED state:
  - o_cmd=1.
  - Request drop -> OPENING.
  - fb=0 while the request is held -> FAULT on the next edge.
- OPENING state:
  - o_cmd=0.
  - fb=0 -> OPEN.
  - Timer reaching T_OPEN-1 -> FAULT.
  - A new request is ignored until OPEN is reached.
- FAULT state:
  - o_cmd=0, latched.
  - i_fault_clr=1 with fb=0 -> OPEN. If fb=1, the clear is ignored.
  - The request must be re-evaluated via OPEN; there is no direct reclose.
- Timers saturate and never wrap.
- Patterns are static; no runtime reconfiguration.

Decomposition:
- Shared package/header holds:
  - State encoding constants: ST_OPEN, ST_CLOSING, ST_CLOSED, ST_OPENING, ST_FAULT.
  - Timer-width helper function.
  - Pattern slicing macro.
- One sub-module, contactor_channel: per-channel FSM plus timer.
  - Inputs: grant, req, fb, fault_clr.
  - Outputs: state, cmd, eff.
- The top instantiates N_CH channels plus the permit/arbitration logic.

Test Plan:
Config for all scenarios: N_CH=4, N_PAT=1, PAT_MASKS=4'b1111 (ring closure), T_CLOSE=T_OPEN=8. The bench returns fb 2 cycles after cmd.
1. Request ch0, ch1, ch2 one at a time -> each o_cmd rises 1 cycle after its request and o_closed follows; then request ch3 -> o_blocked[3]=1 and o_cmd[3] stays 0 indefinitely.
2. ch0 and ch1 closed, then request ch2 and ch3 in the same cycle -> ch2 granted (o_cmd=4'b0111); ch3 blocked from the next cycle because ch2 counts as eff while CLOSING.
3. Request ch1 with fb held 0 -> o_fault[1]=1 and o_cmd[1]=0 exactly 8 cycles after o_cmd[1] rose; o_closed[1] never set.
4. ch0 CLOSED, force fb[0]=0 -> o_fault[0]=1 next cycle; pulse i_fault_clr with fb=0 -> OPEN, o_fault[0]=0, and ch0 recloses when requested again.
5. Assert i_rst_n=0 while ch2 is CLOSING -> after the next edge all o_* = 0; after release with fb[2] still 1, ch2 faults only if fb persists for 8 cycles.
6. Drop i_req_close[0] during CLOSING -> OPENING with o_cmd[0]=0 next cycle; fb falls -> OPEN, o_busy returns to 0.
